// File: rtl/regfile_pkg.sv
// Shared defaults and index constants for the multi-ported register file.
package regfile_pkg;

  localparam int unsigned XlenDefault = 64;
  localparam int unsigned NregDefault = 32;
  localparam int unsigned RegZero     = 0;

  function automatic int unsigned addr_width(input int unsigned nreg);
    return $clog2(nreg);
  endfunction

  localparam int unsigned AwDefault = addr_width(NregDefault);

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writer scoreboard: issue sets a busy bit, a committed write clears it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NregDefault,
  parameter int unsigned NWR  = 2,
  localparam int unsigned AW  = addr_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                update_i,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_idx_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_idx_i,
  output logic [NREG-1:0]     busy_vec_o
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (update_i) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en_i[w]) busy_d[wr_idx_i[w*AW +: AW]] = 1'b0;
      end
    end
    // Set is applied after clears so a same-cycle issue keeps the bit high.
    if (iss_en_i) busy_d[iss_idx_i] = 1'b1;
    busy_d[RegZero] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with x0 hard-wired to zero, optional RAW bypass and scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XlenDefault,
  parameter int unsigned NREG   = NregDefault,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = addr_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                update_i,
  input  logic [NRD*AW-1:0]   rd_idx_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_idx_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_idx_i,
  output logic [NREG-1:0]     busy_vec_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NWR-1:0]  wr_qual;

  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wr_qual[w] = wr_en_i[w] & update_i & (wr_idx_i[w*AW +: AW] != AW'(RegZero));
    end
  end

  // Later ports overwrite earlier ones, giving the highest port priority.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_qual[w]) regs_d[wr_idx_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .update_i   (update_i),
    .wr_en_i    (wr_qual),
    .wr_idx_i   (wr_idx_i),
    .iss_en_i   (iss_en_i),
    .iss_idx_i  (iss_idx_i),
    .busy_vec_o (busy_vec_o)
  );

  always_comb begin
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] data;
    logic            hit;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NRD; p++) begin
      idx  = rd_idx_i[p*AW +: AW];
      data = regs_q[idx];
      hit  = 1'b0;
      if (BYPASS) begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_qual[w] && wr_idx_i[w*AW +: AW] == idx) begin
            data = wr_data_i[w*XLEN +: XLEN];
            hit  = 1'b1;
          end
        end
      end
      if (!rst && idx != AW'(RegZero)) begin
        rd_data_o[p*XLEN +: XLEN] = data;
        rd_busy_o[p] = busy_vec_o[idx] & ~(hit & ~(iss_en_i & (iss_idx_i == idx)));
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  typedef struct {
    logic            rst;
    logic            upd;
    logic [1:0]      we;
    logic [AW-1:0]   wi [2];
    logic [XLEN-1:0] wd [2];
    logic            ie;
    logic [AW-1:0]   ii;
    logic [AW-1:0]   ri [2];
  } stim_t;

  typedef struct {
    logic [XLEN-1:0] d [2];
    logic [1:0]      busy;
    logic [NREG-1:0] bv;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                update;
  logic [2*AW-1:0]     rd_idx;
  logic [2*XLEN-1:0]   rd_data;
  logic [1:0]          rd_busy;
  logic [1:0]          wr_en;
  logic [2*AW-1:0]     wr_idx;
  logic [2*XLEN-1:0]   wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_idx;
  logic [NREG-1:0]     busy_vec;

  int vectors = 0;
  int miscompares = 0;
  exp_t expq[$];

  logic [XLEN-1:0] mem [NREG];
  bit              pend [NREG];

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .NRD    (2),
    .NWR    (2),
    .BYPASS (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .update_i   (update),
    .rd_idx_i   (rd_idx),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_data_i  (wr_data),
    .iss_en_i   (iss_en),
    .iss_idx_i  (iss_idx),
    .busy_vec_o (busy_vec)
  );

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.upd = 1'b1; s.we = 2'b00; s.ie = 1'b0; s.ii = '0;
    for (int i = 0; i < 2; i++) begin
      s.wi[i] = '0; s.wd[i] = '0; s.ri[i] = '0;
    end
    return s;
  endfunction

  // Index of the last port writing reg r this cycle, or -1 if none commits to it.
  function automatic int last_writer(stim_t s, logic [AW-1:0] r);
    int lw = -1;
    for (int w = 0; w < 2; w++)
      if (s.we[w] && s.upd && s.wi[w] != 0 && s.wi[w] == r) lw = w;
    return lw;
  endfunction

  task automatic cyc(input stim_t s);
    exp_t e;
    int   lw;
    @(posedge clk);
    #2;
    rst     = s.rst;
    update  = s.upd;
    wr_en   = s.we;
    wr_idx  = {s.wi[1], s.wi[0]};
    wr_data = {s.wd[1], s.wd[0]};
    iss_en  = s.ie;
    iss_idx = s.ii;
    rd_idx  = {s.ri[1], s.ri[0]};
    if (s.rst) begin
      for (int i = 0; i < NREG; i++) begin mem[i] = '0; pend[i] = 1'b0; end
    end
    for (int p = 0; p < 2; p++) begin
      lw = last_writer(s, s.ri[p]);
      if (s.rst || s.ri[p] == 0) begin
        e.d[p] = '0; e.busy[p] = 1'b0;
      end else begin
        e.d[p]    = (lw >= 0) ? s.wd[lw] : mem[s.ri[p]];
        e.busy[p] = pend[s.ri[p]] && !(lw >= 0 && !(s.ie && s.ii == s.ri[p]));
      end
    end
    for (int i = 0; i < NREG; i++) e.bv[i] = pend[i];
    expq.push_back(e);
    if (!s.rst) begin
      for (int r = 1; r < NREG; r++) begin
        lw = last_writer(s, AW'(r));
        if (lw >= 0) begin mem[r] = s.wd[lw]; pend[r] = 1'b0; end
      end
      if (s.ie && s.ii != 0) pend[s.ii] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rd_data0", rd_data[XLEN-1:0], e.d[0]);
        chk("rd_data1", rd_data[2*XLEN-1:XLEN], e.d[1]);
        chk("rd_busy", {62'd0, rd_busy}, {62'd0, e.busy});
        chk("busy_vec", {32'd0, busy_vec}, {32'd0, e.bv});
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    rst = 1'b1; update = 1'b0; wr_en = '0; wr_idx = '0; wr_data = '0;
    iss_en = 1'b0; iss_idx = '0; rd_idx = '0;
    for (int i = 0; i < NREG; i++) begin mem[i] = '0; pend[i] = 1'b0; end

    s = idle(); s.rst = 1'b1; s.ri[0] = 5; s.ri[1] = 9;
    cyc(s); cyc(s);

    // x5 write with same-cycle bypass, then registered readback.
    s = idle(); s.we = 2'b01; s.wi[0] = 5; s.wd[0] = 64'hDEAD; s.ri[0] = 5;
    cyc(s);
    s = idle(); s.ri[0] = 5; cyc(s);

    // Dual write to x7: port 1 wins.
    s = idle(); s.we = 2'b11; s.wi[0] = 7; s.wi[1] = 7;
    s.wd[0] = 64'h11; s.wd[1] = 64'h22; s.ri[0] = 7; s.ri[1] = 7;
    cyc(s);
    s = idle(); s.ri[0] = 7; s.ri[1] = 5; cyc(s);

    // x0 is immutable and never busy.
    s = idle(); s.we = 2'b01; s.wi[0] = 0; s.wd[0] = 64'hFFFF; s.ie = 1'b1; s.ii = 0;
    cyc(s);
    s = idle(); cyc(s);

    // Issue beats clear on x3, later plain write clears it.
    s = idle(); s.ie = 1'b1; s.ii = 3; s.ri[0] = 3; cyc(s);
    s = idle(); s.ie = 1'b1; s.ii = 3; s.we = 2'b01; s.wi[0] = 3; s.wd[0] = 64'h33; s.ri[0] = 3;
    cyc(s);
    s = idle(); s.we = 2'b10; s.wi[1] = 3; s.wd[1] = 64'h34; s.ri[0] = 3; cyc(s);
    s = idle(); s.ri[0] = 3; cyc(s);

    // update low drops write and clear, keeps issue.
    s = idle(); s.ie = 1'b1; s.ii = 9; cyc(s);
    s = idle(); s.upd = 1'b0; s.we = 2'b01; s.wi[0] = 9; s.wd[0] = 64'h55; s.ri[0] = 9;
    s.ie = 1'b1; s.ii = 12; cyc(s);
    s = idle(); s.ri[0] = 9; s.ri[1] = 12; cyc(s);

    // Mid-cycle asynchronous reset after writing and issuing x4.
    s = idle(); s.we = 2'b01; s.wi[0] = 4; s.wd[0] = 64'hAA; s.ie = 1'b1; s.ii = 4; cyc(s);
    s = idle(); s.ri[0] = 4; cyc(s);
    s = idle(); s.rst = 1'b1; s.ri[0] = 4; s.we = 2'b01; s.wi[0] = 4; s.wd[0] = 64'h77;
    s.ie = 1'b1; s.ii = 6; cyc(s);
    s = idle(); s.ri[0] = 4; s.ri[1] = 6; cyc(s);

    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.rst = ($urandom_range(0, 49) == 0);
      s.upd = ($urandom_range(0, 3) != 0);
      s.we  = 2'($urandom_range(0, 3));
      s.ie  = ($urandom_range(0, 1) == 1);
      s.ii  = AW'($urandom_range(0, 7));
      for (int i = 0; i < 2; i++) begin
        s.wi[i] = AW'($urandom_range(0, 7));
        s.wd[i] = {$urandom, $urandom};
        s.ri[i] = AW'($urandom_range(0, 7));
      end
      cyc(s);
    end

    @(negedge clk);
    #1;
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
